// File: rtl/proc_sequencer.sv
// proc_sequencer: clocked instruction sequencer for the 4-register datapath.
// Holds a small program memory and issues one 8-bit instruction per step on
// `sig` with a one-cycle `sig_valid` strobe. ALU words (sig[1:0]==2'b11) are
// held for ALU_LAT cycles before the sequencer advances.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_en/addr/data     program memory write port (ignored while busy)
//   start, prog_len       run prog_len instructions from address 0
//   abort                 drop back to IDLE without a done pulse
//   sig, sig_valid        instruction to datapath and its issue strobe
//   alu_active            ALU instruction settle window
//   busy, done, pc        run status, end-of-program pulse, current address
module proc_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned ALU_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          abort,
  output logic [7:0]    sig,
  output logic          sig_valid,
  output logic          alu_active,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ALU,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW:0]   len;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [DEPTH];

  logic [AW:0]   len_clamped_c;
  logic          last_c;

  // Lengths beyond the memory size run the whole memory once, never wrap.
  assign len_clamped_c = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign last_c        = ({1'b0, pc} == (len - (AW+1)'(1)));

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem[load_addr] <= load_data;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sig        <= 8'h00;
      sig_valid  <= 1'b0;
      alu_active <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pc         <= '0;
      len        <= '0;
      cnt        <= '0;
    end else begin
      sig_valid <= 1'b0;
      done      <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // sig and pc are deliberately left holding their last values
        state      <= S_IDLE;
        alu_active <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if (prog_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                len   <= len_clamped_c;
                pc    <= '0;
                busy  <= 1'b1;
                state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            // Synchronous read lands directly in the issue register.
            sig       <= mem[pc];
            sig_valid <= 1'b1;
            state     <= S_ISSUE;
          end
          S_ISSUE: begin
            if (sig[1:0] == 2'b11) begin
              alu_active <= 1'b1;
              cnt        <= CW'(ALU_LAT - 1);
              state      <= S_WAIT_ALU;
            end else if (last_c) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc    <= pc + AW'(1);
              state <= S_FETCH;
            end
          end
          S_WAIT_ALU: begin
            if (cnt == '0) begin
              alu_active <= 1'b0;
              if (last_c) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                pc    <= pc + AW'(1);
                state <= S_FETCH;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Clocked instruction sequencer for the 4-register 8-bit-instruction datapath. It holds a small program memory and issues one instruction per step on `sig` with a one-cycle valid strobe. ALU instructions (`sig[1:0]=2'b11`) are held for a fixed settle window before the next issue. It replaces the hand-driven `sig` bus and the delay-based ALU wait with a synchronous start/busy/done controller.

Parameters:
DEPTH, 16, program memory entries (power of 2, >=2)
AW, 4, address/PC width, log2(DEPTH)
ALU_LAT, 3, cycles `sig` is held after issue of an ALU instruction (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_en  input  1  write program word this cycle
load_addr  input  AW  program write address
load_data  input  8  program word (instruction encoding of `sig`)
start  input  1  begin execution at address 0
prog_len  input  AW+1  number of instructions to run, sampled on accepted start
abort  input  1  stop execution, return to IDLE
sig  output  8  instruction to datapath
sig_valid  output  1  one-cycle strobe: `sig` carries a newly issued instruction
alu_active  output  1  high while an ALU instruction is being held
busy  output  1  high in FETCH/ISSUE/WAIT_ALU
done  output  1  one-cycle pulse at end of program
pc  output  AW  address of current/next instruction

Behaviour:
- Reset values: state=IDLE; `sig`=0, `sig_valid`=0, `alu_active`=0, `busy`=0, `done`=0, `pc`=0, wait counter=0. Program memory is not cleared.
- Program memory write:
  - Accepted only when `busy`=0; ignored while `busy`=1.
  - Write takes effect at the clock edge.
  - Read is synchronous, 1-cycle latency.
- IDLE:
  - `start`=1 with `prog_len`=0 goes to DONE.
  - `start`=1 with `prog_len`>0 latches len, sets `pc`=0, goes to FETCH.
  - If `prog_len`>DEPTH, it is clamped to DEPTH.
- FETCH: memory read of `mem[pc]` is issued; goes to ISSUE next cycle.
- ISSUE:
  - `sig`<=read word; `sig_valid`=1 for exactly this cycle.
  - If `word[1:0]`=11: `alu_active`=1, counter=ALU_LAT-1, go to WAIT_ALU.
  - Otherwise: if `pc`==len-1 go to DONE, else `pc`+=1 and go to FETCH.
- WAIT_ALU:
  - `alu_active`=1 and `sig` is held; counter decrements each cycle.
  - When counter==0: `alu_active`<=0, then advance (`pc`+=1 or DONE) with the same rule as ISSUE.
- DONE: `done`=1 for one cycle, then IDLE. `pc` keeps its last executed address.
- `sig` holds the last issued value between issues and after completion. Only `sig_valid` marks a new instruction, so identical consecutive instructions are each strobed.
- Step timing:
  - Non-ALU instruction: 2 cycles (FETCH+ISSUE).
  - ALU instruction: 2+ALU_LAT cycles.
  - Program of N non-ALU instructions: `done` occurs N*2+1 cycles after the start edge.
- `start` while `busy`=1 is ignored. `start` in the DONE cycle is ignored.
- `abort` (any state except IDLE):
  - Next state is IDLE.
  - `sig_valid`, `alu_active`, `busy` and `done` drop at the next edge.
  - `sig` is held; no `done` pulse.
- Priority: `reset` > `abort` > `start`.
- `reset` mid-program: all outputs return to reset values at the next edge; program contents are retained.
- Wrap-around: `pc` never exceeds len-1. A len==DEPTH program ends at `pc`=DEPTH-1 with no wrap.

Test Plan:
- Load mem[0]=8'hA2 (LDI r0,10), mem[1]=8'h36 (LDI r1,3), mem[2]=8'h05 (r1<-r0); start with `prog_len`=3 -> `sig_valid` pulses on cycles 2,4,6 with `sig`=A2,36,05; `done` on cycle 7; `busy` high cycles 1-6.
- mem[0]=8'h1B (ALU op, `sig[3:2]`=2), `prog_len`=1, ALU_LAT=3 -> `sig_valid` 1 cycle, `alu_active` high 3 cycles with `sig`=1B held, `done` exactly 1 cycle later.
- `prog_len`=0 with `start` -> `done` pulses next cycle; `sig_valid` never asserts; `busy` stays 0.
- `abort` asserted during WAIT_ALU of a 4-instruction program -> IDLE next edge; `alu_active`=0, no `done`; a subsequent `start` reruns from `pc`=0.
- `load_en` with addr 0 / data 8'hFF while `busy` -> mem[0] unchanged (re-run issues the original word); `start` during `busy` -> no restart, `pc` sequence uninterrupted.
- `prog_len`=DEPTH with all non-ALU words; `reset` asserted at `pc`=5 -> all outputs 0 next edge; re-run to completion -> last issue at `pc`=DEPTH-1, `done` once, no wrap.
